// File: rtl/cache_mem_responder_pkg.sv
// Shared cache definitions: responder FSM encoding and the
// address-field width helpers shared with the set-associative cache.
package cache_mem_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WB,
      ST_FILL,
      ST_RESP
   } resp_state_e;

   localparam int CNT_W = 4;

   function automatic int offset_bits(input int line_bytes);
      return $clog2(line_bytes);
   endfunction

   function automatic int index_bits(input int lines);
      return $clog2(lines);
   endfunction

endpackage

// File: rtl/cache_mem_responder_line_ram.sv
// Single-port line-wide backing store with synchronous read/write.
// Contents are never reset.
module line_ram #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 1024,
   parameter int IDX_W = 10
) (
   input  logic             clk,
   input  logic             en_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // one access per cycle: write, or read into the output register
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            mem_q[addr_i] <= wdata_i;
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache: serves dirty-line writebacks
// and line fills against a fixed-latency backing store.
module cache_mem_responder
   import cache_mem_responder_pkg::*;
#(
   parameter int ADDRESS_WIDTH   = 32,
   parameter int LINE_SIZE_BYTES = 64,
   parameter int MEM_LINES       = 1024,
   parameter int READ_LATENCY    = 4,
   parameter int WRITE_LATENCY   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_fill_req,
   input  logic [ADDRESS_WIDTH-1:0]     i_fill_addr,
   input  logic                         i_evict,
   input  logic [ADDRESS_WIDTH-1:0]     i_evict_addr,
   input  logic [LINE_SIZE_BYTES*8-1:0] i_evict_data,
   output logic [LINE_SIZE_BYTES*8-1:0] o_memory_line,
   output logic                         o_memory_response,
   output logic                         o_busy,
   output logic                         o_drop
);

   localparam int OFFSET_BITS    = offset_bits(LINE_SIZE_BYTES);
   localparam int MEM_INDEX_BITS = index_bits(MEM_LINES);
   localparam int LW             = LINE_SIZE_BYTES * 8;

   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

   resp_state_e               state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic                      busy_q;
   logic                      resp_q;
   logic                      drop_q;
   logic                      pend_q;
   logic [LW-1:0]             line_q;
   logic [LW-1:0]             ev_data_q;
   logic [MEM_INDEX_BITS-1:0] ev_idx_q;
   logic [MEM_INDEX_BITS-1:0] fill_idx_q;

   logic [MEM_INDEX_BITS-1:0] fill_idx;
   logic [MEM_INDEX_BITS-1:0] ev_idx;
   logic                      ram_en;
   logic                      ram_we;
   logic [MEM_INDEX_BITS-1:0] ram_addr;
   logic [LW-1:0]             ram_rdata;
   logic                      unused_addr;

   // offset and tag bits above the index select nothing here
   assign fill_idx    = i_fill_addr[OFFSET_BITS +: MEM_INDEX_BITS];
   assign ev_idx      = i_evict_addr[OFFSET_BITS +: MEM_INDEX_BITS];
   assign unused_addr = ^{i_fill_addr, i_evict_addr};

   // array is touched only on the final cycle of WB or FILL
   always_comb begin
      ram_we   = (state_q == ST_WB) && (cnt_q == '0);
      ram_en   = ram_we || ((state_q == ST_FILL) && (cnt_q == '0));
      ram_addr = (state_q == ST_WB) ? ev_idx_q : fill_idx_q;
   end

   line_ram #(
      .WIDTH (LW),
      .DEPTH (MEM_LINES),
      .IDX_W (MEM_INDEX_BITS)
   ) u_line_ram (
      .clk     (clk),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ev_data_q),
      .rdata_o (ram_rdata)
   );

   // transaction FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         resp_q     <= 1'b0;
         drop_q     <= 1'b0;
         pend_q     <= 1'b0;
         line_q     <= '0;
         ev_data_q  <= '0;
         ev_idx_q   <= '0;
         fill_idx_q <= '0;
      end else begin
         resp_q <= 1'b0;
         if (busy_q && (i_fill_req || i_evict)) begin
            drop_q <= 1'b1;
         end
         unique case (state_q)
            ST_IDLE: begin
               if (i_evict) begin
                  ev_idx_q   <= ev_idx;
                  ev_data_q  <= i_evict_data;
                  pend_q     <= i_fill_req;
                  fill_idx_q <= fill_idx;
                  cnt_q      <= WR_LOAD;
                  busy_q     <= 1'b1;
                  state_q    <= ST_WB;
               end else if (i_fill_req) begin
                  fill_idx_q <= fill_idx;
                  cnt_q      <= RD_LOAD;
                  busy_q     <= 1'b1;
                  state_q    <= ST_FILL;
               end
            end
            ST_WB: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else if (pend_q) begin
                  pend_q  <= 1'b0;
                  cnt_q   <= RD_LOAD;
                  state_q <= ST_FILL;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            ST_FILL: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               line_q  <= ram_rdata;
               resp_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_memory_line     = line_q;
   assign o_memory_response = resp_q;
   assign o_busy            = busy_q;
   assign o_drop            = drop_q;

endmodule
